// File: rtl/apb_reg_slave.sv
// APB4 slave with a parametrised register bank, wait states and byte strobes.
// Optional error response when APB_SLVERR_EN is defined.
//
// Ports:
//   pclk, preset        clock, async active-high reset
//   psel, penable       APB select / access phase
//   pwrite, paddr       direction and byte address (held setup..completion)
//   pwdata, pstrb       write data and byte-lane strobes (sampled at commit)
//   prdata              registered read data
//   pready, pslverr     completion and error response
//   regs_o              flat register bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module apb_reg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(NUM_REGS);

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIM =
    ADDR_WIDTH'(NUM_REGS * NB);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READY
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q;
  logic            wr_q;
  logic            err_q;
  logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] prdata_q;

  logic            setup;
  logic            bad;
  logic            commit;
  logic            clr_rd;
  logic [IW-1:0]   idx;

  assign idx   = paddr[LSB +: IW];
  assign bad   = (|(paddr & AMASK)) || (paddr >= ALIM);
  assign setup = (state_q == IDLE) && psel && !penable;

  assign commit = (state_q == READY) && psel && penable
                  && pwrite && wr_q && !err_q;

  // read data is dropped when a transfer completes or is aborted
  assign clr_rd = (state_q == READY)
                  || ((state_q == WAIT) && !psel);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (WAIT_STATES == 0) begin
            state_d = READY;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q <= idx;
        wr_q  <= pwrite;
        err_q <= bad;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      prdata_q <= '0;
    end else if (setup) begin
      prdata_q <= (!pwrite && !bad) ? bank_q[idx] : '0;
    end else if (clr_rd) begin
      prdata_q <= '0;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (commit) begin
      for (int k = 0; k < NB; k++) begin
        if (pstrb[k]) begin
          bank_q[idx_q][k*8 +: 8] <= pwdata[k*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = bank_q[g];
  end

  assign prdata = prdata_q;
  assign pready = (state_q == READY);

`ifdef APB_SLVERR_EN
  assign pslverr = (state_q == READY) && err_q;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: one zero-wait and one two-wait instance.
// Stimulus pushes expected completions; a negedge monitor pops and compares.
module tb_apb_reg_slave;

  logic         pclk = 1'b0;
  logic         preset = 1'b1;
  logic         psel_a = 1'b0;
  logic         psel_b = 1'b0;
  logic         penable = 1'b0;
  logic         pwrite = 1'b0;
  logic [31:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;

  logic [31:0]  prdata_a, prdata_b;
  logic         pready_a, pready_b;
  logic         pslverr_a, pslverr_b;
  logic [127:0] regs_a, regs_b;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  typedef struct {
    bit          dut;
    bit          rd;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  apb_reg_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(4), .WAIT_STATES(0)
  ) dut_a (
    .pclk(pclk), .preset(preset),
    .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .regs_o(regs_a)
  );

  apb_reg_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_REGS(4), .WAIT_STATES(2)
  ) dut_b (
    .pclk(pclk), .preset(preset),
    .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .regs_o(regs_b)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every pready must match the head of the scoreboard
  always @(negedge pclk) begin
    exp_t e;
    if (!preset) begin
      if (pready_a || pready_b) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL spurious_pready: a=%0b b=%0b expected none",
                   pready_a, pready_b);
        end else begin
          e = sb.pop_front();
          chk("ready_dut", {127'd0, pready_b}, {127'd0, e.dut});
          chk("ready_cycle", 128'(cyc), 128'(e.cyc));
          chk("pslverr", e.dut ? pslverr_b : pslverr_a, e.err);
          if (e.rd)
            chk("prdata", e.dut ? prdata_b : prdata_a, e.data);
        end
      end
      if ((pslverr_a && !pready_a) || (pslverr_b && !pready_b)) begin
        vecs++;
        errs++;
        $display("FAIL pslverr_alone: a=%0b b=%0b expected 0",
                 pslverr_a, pslverr_b);
      end
    end
  end

  task automatic xfer(input bit d, input bit w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] ed,
                      input bit ee);
    exp_t e;
    bit got;
    @(posedge pclk); #1;
    psel_a  = !d;
    psel_b  = d;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = wd;
    pstrb   = s;
    e.dut  = d;
    e.rd   = !w;
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc + 1 + (d ? 2 : 0);
    sb.push_back(e);
    @(posedge pclk); #1;
    penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (d ? pready_b : pready_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      vecs++;
      errs++;
      $display("FAIL timeout: no pready at addr %0h expected one", a);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
    end
  endtask

  localparam logic [31:0] W0 = 32'h0A0A_0001;
  localparam logic [31:0] W1 = 32'h0B0B_0002;
  localparam logic [31:0] W2 = 32'h0C0C_0003;
  localparam logic [31:0] W3 = 32'h0D0D_0004;

  initial begin
    #12;
    chk("rst_pready", {pready_a, pready_b}, 0);
    chk("rst_pslverr", {pslverr_a, pslverr_b}, 0);
    chk("rst_prdata", {prdata_a, prdata_b}, 0);
    chk("rst_regs", regs_a | regs_b, 0);
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(1);

    // readback of a freshly reset bank
    for (int i = 0; i < 4; i++)
      xfer(0, 0, 32'(i*4), 0, 0, 32'h0, 0);
    idle(1);

    // byte strobes
    xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    xfer(0, 1, 32'h4, 32'h1122_3344, 4'b0101, 0, 0);
    xfer(0, 0, 32'h4, 0, 0, 32'hDE22_BE44, 0);
    xfer(0, 1, 32'h4, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    idle(1);
    chk("regs_a_r1", regs_a[63:32], 32'hDE22_BE44);

    // wait states on the second instance
    xfer(1, 1, 32'h8, 32'h0000_0008, 4'hF, 0, 0);
    xfer(1, 0, 32'h8, 0, 0, 32'h0000_0008, 0);
    idle(1);
    chk("regs_b_r2", regs_b[95:64], 32'h8);

    // back-to-back writes, psel held high
    xfer(0, 1, 32'h0, W0, 4'hF, 0, 0);
    xfer(0, 1, 32'h4, W1, 4'hF, 0, 0);
    xfer(0, 1, 32'h8, W2, 4'hF, 0, 0);
    xfer(0, 1, 32'hC, W3, 4'hF, 0, 0);
    idle(1);
    chk("regs_a_b2b", regs_a, {W3, W2, W1, W0});

    // invalid addresses: out of range write, misaligned read
    xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'hF, 0, SLV);
    xfer(0, 0, 32'h2, 0, 0, 32'h0, SLV);
    xfer(0, 0, 32'hC, 0, 0, W3, 0);
    idle(1);
    chk("regs_a_err", regs_a, {W3, W2, W1, W0});

    // abort: psel dropped in cycle 2 of a waited write
    @(posedge pclk); #1;
    psel_b  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0;
    pwdata  = 32'h55;
    pstrb   = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b  = 1'b0;
    penable = 1'b0;
    idle(6);
    chk("abort_reg0", regs_b[31:0], 0);

    // reset in cycle 2 of a waited read
    @(posedge pclk); #1;
    psel_b  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h8;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("hold_prdata", prdata_b, 32'h8);
    preset = 1'b1;
    #1;
    chk("mrst_prdata", prdata_b, 0);
    chk("mrst_ready", {pready_b, pslverr_b}, 0);
    chk("mrst_regs", regs_a | regs_b, 0);
    psel_b  = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(2);

    xfer(0, 0, 32'h4, 0, 0, 32'h0, 0);
    idle(4);
    chk("sb_empty", 128'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
